// File: rtl/serial_adder_ctrl_if.sv
// Operation request/result bundle for the bit-serial adder controller.
// The requester drives the operands and start; the controller drives status and result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             SUB;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             OVF;

  modport master (
    output start, A, B, Cin, SUB,
    input  ready, busy, done, S, Cout, OVF
  );

  modport slave (
    input  start, A, B, Cin, SUB,
    output ready, busy, done, S, Cout, OVF
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one NAND-only full adder is reused over WIDTH cycles,
// LSB first, behind an IDLE/RUN/DONE handshake with registered result and flags.
module full_adder_nand (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  logic w_n1, w_n2, w_n3, w_x, w_n4, w_n5, w_n6;

  // Classic nine-gate NAND full adder; w_x is a^b.
  assign w_n1   = ~(i_a & i_b);
  assign w_n2   = ~(i_a & w_n1);
  assign w_n3   = ~(i_b & w_n1);
  assign w_x    = ~(w_n2 & w_n3);
  assign w_n4   = ~(w_x & i_cin);
  assign w_n5   = ~(w_x & w_n4);
  assign w_n6   = ~(i_cin & w_n4);
  assign o_s    = ~(w_n5 & w_n6);
  assign o_cout = ~(w_n4 & w_n1);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_cout;

  full_adder_nand u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_a_sh  <= bus.A;
            // Subtraction is A + ~B + 1; Cin plays no part there.
            r_b_sh  <= bus.SUB ? ~bus.B : bus.B;
            r_carry <= bus.SUB ? 1'b1 : bus.Cin;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_carry  <= w_cout;
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt    <= r_cnt + ONE;
          if (r_cnt == LAST) begin
            // On the MSB, r_carry is the carry into it and w_cout the carry out.
            r_state <= DONE;
            r_s     <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_cout  <= w_cout;
            r_ovf   <= r_carry ^ w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.S     = r_s;
  assign bus.Cout  = r_cout;
  assign bus.OVF   = r_ovf;
endmodule
